// File: rtl/afe_ctrl_pkg.sv
// Shared types and constants for the AFE LED phase scheduler.
// The AMBIENT_PHASE_EN build option selects the three-slot frame in led_phase_scheduler.
package afe_ctrl_pkg;

   localparam int unsigned DC_W    = 7;
   localparam int unsigned PGA_W   = 4;
   localparam int unsigned DRIVE_W = 4;

   localparam logic [DC_W-1:0] DC_COMP_MID = 7'd64;

   typedef enum logic [1:0] {
      StIdle,
      StRed,
      StIr,
      StAmb
   } afe_state_e;

   typedef struct packed {
      logic [DC_W-1:0]    red_dc;
      logic [PGA_W-1:0]   red_pga;
      logic [DC_W-1:0]    ir_dc;
      logic [PGA_W-1:0]   ir_pga;
      logic [DRIVE_W-1:0] drive;
   } afe_cfg_t;

   localparam afe_cfg_t CFG_RESET = '{
      red_dc:  DC_COMP_MID,
      red_pga: '0,
      ir_dc:   DC_COMP_MID,
      ir_pga:  '0,
      drive:   '0
   };

endpackage

// File: rtl/led_phase_scheduler_if.sv
// Sample-pair stream from the LED phase scheduler to the SpO2 datapath.
// master = scheduler (produces pairs), slave = downstream consumer.
interface led_phase_scheduler_if #(
   parameter int unsigned ADC_W = 8
);

   logic [ADC_W-1:0] red_sample;
   logic [ADC_W-1:0] ir_sample;
   logic             sample_valid;
   logic             sample_ready;
   logic             overrun;

   modport master (
      output red_sample,
      output ir_sample,
      output sample_valid,
      output overrun,
      input  sample_ready
   );

   modport slave (
      input  red_sample,
      input  ir_sample,
      input  sample_valid,
      input  overrun,
      output sample_ready
   );

endinterface

// File: rtl/slot_timer.sv
// Per-slot cycle counter for the LED scheduler: counts 0..SLOT_CYCLES-1 while enabled,
// flags the final cycle of each slot, and returns to 0 on clear.
module slot_timer #(
   parameter int unsigned SLOT_CYCLES = 10
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic slot_end_o
);

   localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SLOT_CYCLES - 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign slot_end_o = en_i && !clear_i && (cnt_q == CntLast);

endmodule

// File: rtl/led_phase_scheduler.sv
// Time-multiplexes the RED/IR LEDs, applies per-channel DC/PGA settings and emits sample pairs.
// Define AMBIENT_PHASE_EN for a third, LEDs-off slot whose sample is subtracted from both channels.
module led_phase_scheduler
   import afe_ctrl_pkg::*;
#(
   parameter int unsigned SLOT_CYCLES   = 10,
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned ADC_W         = 8
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 cfg_valid,
   input  logic [DC_W-1:0]      cfg_red_dc,
   input  logic [PGA_W-1:0]     cfg_red_pga,
   input  logic [DC_W-1:0]      cfg_ir_dc,
   input  logic [PGA_W-1:0]     cfg_ir_pga,
   input  logic [DRIVE_W-1:0]   cfg_drive,
   input  logic [ADC_W-1:0]     ADC,
   output logic                 LED_RED,
   output logic                 LED_IR,
   output logic [DC_W-1:0]      DC_Comp,
   output logic [PGA_W-1:0]     PGA_Gain,
   output logic [DRIVE_W-1:0]   LED_DRIVE,
   led_phase_scheduler_if.master smp
);

   if (SLOT_CYCLES < SETTLE_CYCLES + 1) begin : g_cfg_check
      $error("SLOT_CYCLES must leave at least one cycle after SETTLE_CYCLES");
   end

`ifdef AMBIENT_PHASE_EN
   localparam afe_state_e LastSlot = StAmb;
`else
   localparam afe_state_e LastSlot = StIr;
`endif

   afe_state_e state_d, state_q;
   afe_cfg_t   shadow_d, shadow_q;
   afe_cfg_t   frame_d, frame_q;
   logic       shadow_valid_d, shadow_valid_q;

   logic               led_red_d, led_red_q;
   logic               led_ir_d, led_ir_q;
   logic [DC_W-1:0]    dc_d, dc_q;
   logic [PGA_W-1:0]   pga_d, pga_q;
   logic [DRIVE_W-1:0] drive_d, drive_q;

   logic [ADC_W-1:0] red_cap_d, red_cap_q;
   logic [ADC_W-1:0] ir_cap_d, ir_cap_q;
`ifdef AMBIENT_PHASE_EN
   logic [ADC_W-1:0] amb_cap_d, amb_cap_q;
`endif
   logic             pair_done_d, pair_done_q;

   logic [ADC_W-1:0] red_new, ir_new;
   logic [ADC_W-1:0] red_smp_d, red_smp_q;
   logic [ADC_W-1:0] ir_smp_d, ir_smp_q;
   logic             valid_d, valid_q;
   logic             overrun_d, overrun_q;

   logic slot_end;

   slot_timer #(
      .SLOT_CYCLES(SLOT_CYCLES)
   ) u_slot_timer (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .clear_i   (!enable),
      .en_i      (state_q != StIdle),
      .slot_end_o(slot_end)
   );

   always_comb begin
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q | cfg_valid;
      if (cfg_valid) begin
         shadow_d = '{
            red_dc:  cfg_red_dc,
            red_pga: cfg_red_pga,
            ir_dc:   cfg_ir_dc,
            ir_pga:  cfg_ir_pga,
            drive:   cfg_drive
         };
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (shadow_valid_q) state_d = StRed;
         StRed:  if (slot_end) state_d = StIr;
         StIr: begin
            if (slot_end) begin
`ifdef AMBIENT_PHASE_EN
               state_d = StAmb;
`else
               state_d = StRed;
`endif
            end
         end
`ifdef AMBIENT_PHASE_EN
         StAmb:  if (slot_end) state_d = StRed;
`endif
         default: state_d = StIdle;
      endcase
      if (!enable) state_d = StIdle;
   end

   // Settings are frozen per frame; shadow_d (not shadow_q) so a same-edge cfg_valid wins.
   always_comb begin
      frame_d = frame_q;
      if (state_d == StRed && state_q != StRed) frame_d = shadow_d;

      led_red_d = 1'b0;
      led_ir_d  = 1'b0;
      dc_d      = DC_COMP_MID;
      pga_d     = '0;
      drive_d   = '0;
      unique case (state_d)
         StRed: begin
            led_red_d = 1'b1;
            dc_d      = frame_d.red_dc;
            pga_d     = frame_d.red_pga;
            drive_d   = frame_d.drive;
         end
         StIr: begin
            led_ir_d = 1'b1;
            dc_d     = frame_d.ir_dc;
            pga_d    = frame_d.ir_pga;
            drive_d  = frame_d.drive;
         end
`ifdef AMBIENT_PHASE_EN
         StAmb: begin
            dc_d    = frame_d.ir_dc;
            pga_d   = frame_d.ir_pga;
            drive_d = frame_d.drive;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      red_cap_d = red_cap_q;
      ir_cap_d  = ir_cap_q;
`ifdef AMBIENT_PHASE_EN
      amb_cap_d = amb_cap_q;
`endif
      if (slot_end) begin
         unique case (state_q)
            StRed:   red_cap_d = ADC;
            StIr:    ir_cap_d  = ADC;
`ifdef AMBIENT_PHASE_EN
            StAmb:   amb_cap_d = ADC;
`endif
            default: ;
         endcase
      end
      pair_done_d = enable && slot_end && (state_q == LastSlot);
   end

`ifdef AMBIENT_PHASE_EN
   function automatic logic [ADC_W-1:0] sat0_sub(input logic [ADC_W-1:0] a,
                                                 input logic [ADC_W-1:0] b);
      logic [ADC_W:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      return diff[ADC_W] ? '0 : diff[ADC_W-1:0];
   endfunction

   assign red_new = sat0_sub(red_cap_q, amb_cap_q);
   assign ir_new  = sat0_sub(ir_cap_q, amb_cap_q);
`else
   assign red_new = red_cap_q;
   assign ir_new  = ir_cap_q;
`endif

   // Pair publication runs one cycle behind the last capture, leaving a cycle for the subtractor.
   always_comb begin
      red_smp_d = red_smp_q;
      ir_smp_d  = ir_smp_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (!enable) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end else if (pair_done_q) begin
         red_smp_d = red_new;
         ir_smp_d  = ir_new;
         valid_d   = 1'b1;
         if (valid_q && !smp.sample_ready) overrun_d = 1'b1;
      end else if (valid_q && smp.sample_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         shadow_q       <= CFG_RESET;
         frame_q        <= CFG_RESET;
         shadow_valid_q <= 1'b0;
         led_red_q      <= 1'b0;
         led_ir_q       <= 1'b0;
         dc_q           <= DC_COMP_MID;
         pga_q          <= '0;
         drive_q        <= '0;
         red_cap_q      <= '0;
         ir_cap_q       <= '0;
`ifdef AMBIENT_PHASE_EN
         amb_cap_q      <= '0;
`endif
         pair_done_q    <= 1'b0;
         red_smp_q      <= '0;
         ir_smp_q       <= '0;
         valid_q        <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         shadow_q       <= shadow_d;
         frame_q        <= frame_d;
         shadow_valid_q <= shadow_valid_d;
         led_red_q      <= led_red_d;
         led_ir_q       <= led_ir_d;
         dc_q           <= dc_d;
         pga_q          <= pga_d;
         drive_q        <= drive_d;
         red_cap_q      <= red_cap_d;
         ir_cap_q       <= ir_cap_d;
`ifdef AMBIENT_PHASE_EN
         amb_cap_q      <= amb_cap_d;
`endif
         pair_done_q    <= pair_done_d;
         red_smp_q      <= red_smp_d;
         ir_smp_q       <= ir_smp_d;
         valid_q        <= valid_d;
         overrun_q      <= overrun_d;
      end
   end

   assign LED_RED          = led_red_q;
   assign LED_IR           = led_ir_q;
   assign DC_Comp          = dc_q;
   assign PGA_Gain         = pga_q;
   assign LED_DRIVE        = drive_q;
   assign smp.red_sample   = red_smp_q;
   assign smp.ir_sample    = ir_smp_q;
   assign smp.sample_valid = valid_q;
   assign smp.overrun      = overrun_q;

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Directed bench for led_phase_scheduler; ADC values are placed on the capture cycles the bench
// predicts from its own cycle count, with junk everywhere else.
module tb_led_phase_scheduler;
   import afe_ctrl_pkg::*;

   localparam int SLOT = 10;
`ifdef AMBIENT_PHASE_EN
   localparam int NSLOT = 3;
`else
   localparam int NSLOT = 2;
`endif
   localparam int F   = NSLOT * SLOT;
   localparam int LAT = F + 1;

   logic               CLK = 1'b0;
   logic               rst_n;
   logic               enable;
   logic               cfg_valid;
   logic [DC_W-1:0]    cfg_red_dc, cfg_ir_dc;
   logic [PGA_W-1:0]   cfg_red_pga, cfg_ir_pga;
   logic [DRIVE_W-1:0] cfg_drive;
   logic [7:0]         ADC;
   logic               LED_RED, LED_IR;
   logic [DC_W-1:0]    DC_Comp;
   logic [PGA_W-1:0]   PGA_Gain;
   logic [DRIVE_W-1:0] LED_DRIVE;

   led_phase_scheduler_if #(.ADC_W(8)) smp_if ();

   led_phase_scheduler #(
      .SLOT_CYCLES  (SLOT),
      .SETTLE_CYCLES(3),
      .ADC_W        (8)
   ) dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .enable     (enable),
      .cfg_valid  (cfg_valid),
      .cfg_red_dc (cfg_red_dc),
      .cfg_red_pga(cfg_red_pga),
      .cfg_ir_dc  (cfg_ir_dc),
      .cfg_ir_pga (cfg_ir_pga),
      .cfg_drive  (cfg_drive),
      .ADC        (ADC),
      .LED_RED    (LED_RED),
      .LED_IR     (LED_IR),
      .DC_Comp    (DC_Comp),
      .PGA_Gain   (PGA_Gain),
      .LED_DRIVE  (LED_DRIVE),
      .smp        (smp_if)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [7:0] v_red[2];
   logic [7:0] v_ir[2];
   logic [7:0] v_amb[2];

   // cyc 0 is the first RED cycle; the last cycle of each slot carries the frame's value.
   function automatic logic [7:0] adc_for(input int c);
      int s, f;
      if (c < 0 || (c % SLOT) != SLOT - 1) return 8'hC3 ^ 8'(c);
      s = (c % F) / SLOT;
      f = (c / F) % 2;
      if (s == 0) return v_red[f];
      if (s == 1) return v_ir[f];
      return v_amb[f];
   endfunction

   function automatic logic [7:0] exp_red(input int f);
`ifdef AMBIENT_PHASE_EN
      return (v_red[f] > v_amb[f]) ? v_red[f] - v_amb[f] : 8'h00;
`else
      return v_red[f];
`endif
   endfunction

   function automatic logic [7:0] exp_ir(input int f);
`ifdef AMBIENT_PHASE_EN
      return (v_ir[f] > v_amb[f]) ? v_ir[f] - v_amb[f] : 8'h00;
`else
      return v_ir[f];
`endif
   endfunction

   task automatic step_run();
      ADC = adc_for(cyc);
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      cfg_valid = 1'b0;
      smp_if.sample_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1 rst_n = 1'b1;
   endtask

   task automatic program_cfg(input logic [6:0] rd, input logic [3:0] rp, input logic [6:0] id,
                              input logic [3:0] ip, input logic [3:0] dr);
      cfg_red_dc = rd;
      cfg_red_pga = rp;
      cfg_ir_dc = id;
      cfg_ir_pga = ip;
      cfg_drive = dr;
      cfg_valid = 1'b1;
      step_run();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if ({LED_RED, LED_IR} !== 2'b00) begin
         n_fail++; $display("FAIL reset_leds: got %b want 00", {LED_RED, LED_IR}); end
      n_tests++; if (DC_Comp !== DC_COMP_MID) begin
         n_fail++; $display("FAIL reset_dc: got %0d want 64", DC_Comp); end
      n_tests++; if ({PGA_Gain, LED_DRIVE} !== 8'h00) begin
         n_fail++; $display("FAIL reset_pga_drive: got %h want 00", {PGA_Gain, LED_DRIVE}); end
      n_tests++; if ({smp_if.red_sample, smp_if.ir_sample} !== 16'h0000) begin
         n_fail++; $display("FAIL reset_samples: got %h want 0000",
                            {smp_if.red_sample, smp_if.ir_sample}); end
      n_tests++; if ({smp_if.sample_valid, smp_if.overrun} !== 2'b00) begin
         n_fail++; $display("FAIL reset_valid_ovr: got %b want 00",
                            {smp_if.sample_valid, smp_if.overrun}); end
      // Enabled but never configured: must stay idle.
      enable = 1'b1;
      repeat (3) step_run();
      n_tests++; if ({LED_RED, LED_IR} !== 2'b00) begin
         n_fail++; $display("FAIL idle_no_cfg: got %b want 00", {LED_RED, LED_IR}); end
      enable = 1'b0;
      step_run();
   endtask

   task automatic test_basic();
      logic e_red, e_ir;
      logic [6:0] e_dc;
      logic [3:0] e_pga;
      int s;
      v_red[0] = 8'h80; v_ir[0] = 8'h30; v_amb[0] = 8'h10;
      v_red[1] = 8'h44; v_ir[1] = 8'h22; v_amb[1] = 8'h05;
      program_cfg(7'd40, 4'd5, 7'd70, 4'd9, 4'd6);
      enable = 1'b1;
      cyc = -1;
      step_run();
      for (int c = 0; c <= LAT; c++) begin
         s = (cyc % F) / SLOT;
         e_red = (s == 0);
         e_ir = (s == 1);
         e_dc = (s == 0) ? 7'd40 : 7'd70;
         e_pga = (s == 0) ? 4'd5 : 4'd9;
         n_tests++;
         if ({LED_RED, LED_IR, DC_Comp, PGA_Gain, LED_DRIVE} !== {e_red, e_ir, e_dc, e_pga, 4'd6})
         begin
            n_fail++;
            $display("FAIL basic_slot cyc=%0d: got led=%b%b dc=%0d pga=%0d drv=%0d want %b%b %0d %0d 6",
                     cyc, LED_RED, LED_IR, DC_Comp, PGA_Gain, LED_DRIVE, e_red, e_ir, e_dc, e_pga);
         end
         n_tests++; if (smp_if.sample_valid !== (cyc == LAT)) begin
            n_fail++; $display("FAIL basic_valid cyc=%0d: got %b want %b",
                               cyc, smp_if.sample_valid, (cyc == LAT)); end
         if (c < LAT) step_run();
      end
      n_tests++; if ({smp_if.red_sample, smp_if.ir_sample} !== {exp_red(0), exp_ir(0)}) begin
         n_fail++; $display("FAIL basic_data: got %h/%h want %h/%h", smp_if.red_sample,
                            smp_if.ir_sample, exp_red(0), exp_ir(0)); end
      n_tests++; if (smp_if.overrun !== 1'b0) begin
         n_fail++; $display("FAIL basic_overrun: got %b want 0", smp_if.overrun); end
   endtask

   task automatic test_overrun();
      while (cyc < 2 * F) step_run();
      n_tests++; if ({smp_if.sample_valid, smp_if.overrun, smp_if.red_sample} !==
                     {1'b1, 1'b0, exp_red(0)}) begin
         n_fail++; $display("FAIL ovr_before: got v=%b o=%b red=%h want 1 0 %h",
                            smp_if.sample_valid, smp_if.overrun, smp_if.red_sample, exp_red(0)); end
      step_run();
      n_tests++; if ({smp_if.sample_valid, smp_if.overrun} !== 2'b11) begin
         n_fail++; $display("FAIL ovr_flag: got v=%b o=%b want 1 1",
                            smp_if.sample_valid, smp_if.overrun); end
      n_tests++; if ({smp_if.red_sample, smp_if.ir_sample} !== {exp_red(1), exp_ir(1)}) begin
         n_fail++; $display("FAIL ovr_data: got %h/%h want %h/%h", smp_if.red_sample,
                            smp_if.ir_sample, exp_red(1), exp_ir(1)); end
      smp_if.sample_ready = 1'b1;
      step_run();
      n_tests++; if ({smp_if.sample_valid, smp_if.overrun} !== 2'b01) begin
         n_fail++; $display("FAIL ovr_accept: got v=%b o=%b want 0 1",
                            smp_if.sample_valid, smp_if.overrun); end
   endtask

   task automatic test_cfg_midframe();
      while ((cyc % F) != 12) step_run();
      program_cfg(7'd50, 4'd5, 7'd70, 4'd9, 4'd6);
      while ((cyc % F) != 0) begin
         n_tests++; if (DC_Comp !== 7'd70) begin
            n_fail++; $display("FAIL midcfg_hold cyc=%0d: got %0d want 70", cyc, DC_Comp); end
         step_run();
      end
      n_tests++; if ({LED_RED, DC_Comp, PGA_Gain} !== {1'b1, 7'd50, 4'd5}) begin
         n_fail++; $display("FAIL midcfg_apply: got led=%b dc=%0d pga=%0d want 1 50 5",
                            LED_RED, DC_Comp, PGA_Gain); end
   endtask

   task automatic test_cfg_boundary();
      while ((cyc % F) != F - 1) step_run();
      program_cfg(7'd33, 4'd5, 7'd70, 4'd9, 4'd6);
      n_tests++; if ({LED_RED, DC_Comp} !== {1'b1, 7'd33}) begin
         n_fail++; $display("FAIL boundary_cfg: got led=%b dc=%0d want 1 33", LED_RED, DC_Comp); end
   endtask

   task automatic test_abort();
      while ((cyc % F) != 4) step_run();
      enable = 1'b0;
      step_run();
      n_tests++; if ({LED_RED, LED_IR, smp_if.sample_valid, smp_if.overrun} !== 4'b0000) begin
         n_fail++; $display("FAIL abort_idle: got led=%b%b v=%b o=%b want 00 0 0",
                            LED_RED, LED_IR, smp_if.sample_valid, smp_if.overrun); end
      repeat (3) step_run();
      n_tests++; if ({LED_RED, LED_IR} !== 2'b00) begin
         n_fail++; $display("FAIL abort_stay: got %b want 00", {LED_RED, LED_IR}); end
      enable = 1'b1;
      cyc = -1;
      step_run();
      n_tests++; if ({LED_RED, LED_IR, DC_Comp} !== {2'b10, 7'd33}) begin
         n_fail++; $display("FAIL abort_restart: got led=%b%b dc=%0d want 10 33",
                            LED_RED, LED_IR, DC_Comp); end
      while (cyc < LAT) begin
         step_run();
         n_tests++; if (smp_if.sample_valid !== (cyc == LAT)) begin
            n_fail++; $display("FAIL abort_valid cyc=%0d: got %b want %b",
                               cyc, smp_if.sample_valid, (cyc == LAT)); end
      end
      n_tests++; if ({smp_if.red_sample, smp_if.ir_sample} !== {exp_red(0), exp_ir(0)}) begin
         n_fail++; $display("FAIL abort_data: got %h/%h want %h/%h", smp_if.red_sample,
                            smp_if.ir_sample, exp_red(0), exp_ir(0)); end
   endtask

   task automatic test_reset_mid_ir();
      while ((cyc % F) != 15) step_run();
      n_tests++; if (LED_IR !== 1'b1) begin
         n_fail++; $display("FAIL midir_pre: got LED_IR=%b want 1", LED_IR); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if ({LED_RED, LED_IR, DC_Comp, PGA_Gain, LED_DRIVE} !==
                     {2'b00, DC_COMP_MID, 4'd0, 4'd0}) begin
         n_fail++; $display("FAIL midir_rst_afe: got led=%b%b dc=%0d pga=%0d drv=%0d want 00 64 0 0",
                            LED_RED, LED_IR, DC_Comp, PGA_Gain, LED_DRIVE); end
      n_tests++; if ({smp_if.red_sample, smp_if.ir_sample, smp_if.sample_valid, smp_if.overrun}
                     !== 18'h0) begin
         n_fail++; $display("FAIL midir_rst_smp: got %h/%h v=%b o=%b want 0/0 0 0",
                            smp_if.red_sample, smp_if.ir_sample, smp_if.sample_valid,
                            smp_if.overrun); end
      @(posedge CLK);
      #1 rst_n = 1'b1;
      repeat (3) step_run();
      n_tests++; if ({LED_RED, LED_IR, DC_Comp} !== {2'b00, DC_COMP_MID}) begin
         n_fail++; $display("FAIL midir_after: got led=%b%b dc=%0d want 00 64",
                            LED_RED, LED_IR, DC_Comp); end
   endtask

`ifdef AMBIENT_PHASE_EN
   task automatic test_ambient();
      do_reset();
      smp_if.sample_ready = 1'b1;
      v_red[0] = 8'h90; v_ir[0] = 8'h20; v_amb[0] = 8'h30;
      program_cfg(7'd40, 4'd5, 7'd70, 4'd9, 4'd6);
      enable = 1'b1;
      cyc = -1;
      step_run();
      while (cyc < LAT) step_run();
      n_tests++; if ({smp_if.sample_valid, smp_if.red_sample, smp_if.ir_sample} !==
                     {1'b1, 8'h60, 8'h00}) begin
         n_fail++; $display("FAIL ambient_sub: got v=%b %h/%h want 1 60/00",
                            smp_if.sample_valid, smp_if.red_sample, smp_if.ir_sample); end
   endtask
`endif

   initial begin
      ADC = 8'h00;
      cfg_red_dc = '0; cfg_red_pga = '0; cfg_ir_dc = '0; cfg_ir_pga = '0; cfg_drive = '0;
      test_reset();
      test_basic();
      test_overrun();
      test_cfg_midframe();
      test_cfg_boundary();
      test_abort();
      test_reset_mid_ir();
`ifdef AMBIENT_PHASE_EN
      test_ambient();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
